// File: rtl/kronos_dbus_wb_pkg.sv
// Shared types for the Kronos data-bus bridge: FSM state encoding and watchdog sizing.
package kronos_types;

    typedef enum logic [1:0] {
        DBUS_IDLE = 2'd0,
        DBUS_BUS  = 2'd1,
        DBUS_RESP = 2'd2
    } dbus_state_e;

    // Counter must hold values 0..TIMEOUT; a disabled watchdog still gets one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/kronos_dbus_wdog.sv
// Bus watchdog: counts strobe cycles without a slave response and flags expiry.
module kronos_dbus_wdog
    import kronos_types::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = wdog_width(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry lands on the strobe cycle after TIMEOUT silent cycles, so the
    // core sees the error TIMEOUT+1 cycles after the strobe went up.
    if (TIMEOUT == 0) begin : g_off
        assign expire_o = 1'b0;
    end else begin : g_on
        assign expire_o = en_i && (cnt_q == CW'(TIMEOUT));
    end

endmodule

// File: rtl/kronos_dbus_wb.sv
// Execute-stage data port to Wishbone B4 classic single-beat master, with watchdog and error capture.
module kronos_dbus_wb
    import kronos_types::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    dbus_state_e state_q, state_d;

    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d, eaddr_q, eaddr_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d, cyc_q, cyc_d, ack_q, ack_d, berr_q, berr_d;
    logic        wd_clr, wd_en, wd_expire;

    kronos_dbus_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdata_d = rdata_q;
        eaddr_d = eaddr_q;
        ack_d   = 1'b0;
        berr_d  = 1'b0;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;

        case (state_q)
            DBUS_IDLE: begin
                if (data_req) begin
                    adr_d   = data_addr;
                    dat_d   = data_wr_data;
                    sel_d   = data_mask;
                    we_d    = data_wr_en;
                    cyc_d   = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = DBUS_BUS;
                end
            end
            DBUS_BUS: begin
                wd_en = 1'b1;
                // Slave error outranks a simultaneous ack; timeout is treated as an error.
                if (wb_err_i || (!wb_ack_i && wd_expire)) begin
                    rdata_d = ERR_RDATA;
                    eaddr_d = adr_q;
                    berr_d  = 1'b1;
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DBUS_RESP;
                end else if (wb_ack_i) begin
                    rdata_d = wb_dat_i;
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DBUS_RESP;
                end
            end
            DBUS_RESP: begin
                state_d = DBUS_IDLE;
            end
            default: begin
                state_d = DBUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DBUS_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdata_q <= '0;
            eaddr_q <= '0;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            eaddr_q <= eaddr_d;
            ack_q   <= ack_d;
            berr_q  <= berr_d;
        end
    end

    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign data_rd_data = rdata_q;
    assign data_ack     = ack_q;
    assign bus_err      = berr_q;
    assign err_addr     = eaddr_q;

endmodule

// File: tb/tb_kronos_dbus_wb.sv
// Directed plus randomized bench for kronos_dbus_wb against a transaction-level reference model.
module tb_kronos_dbus_wb;

    localparam logic [31:0] ERR1 = 32'hBADC0DE5;
    localparam logic [31:0] ERR2 = 32'hE0E0E0E0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Main instance, default watchdog
    logic [31:0] data_addr = '0, data_wr_data = '0, wb_dat_i = '0;
    logic [3:0]  data_mask = '0;
    logic        data_wr_en = 1'b0, data_req = 1'b0, wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [31:0] data_rd_data, wb_adr_o, wb_dat_o, err_addr;
    logic [3:0]  wb_sel_o;
    logic        data_ack, wb_we_o, wb_cyc_o, wb_stb_o, bus_err;

    // Short-watchdog instance
    logic [31:0] t_addr = '0, t_wdata = '0, t_wb_dat_i = '0;
    logic [3:0]  t_mask = '0;
    logic        t_we = 1'b0, t_req = 1'b0, t_wb_ack_i = 1'b0, t_wb_err_i = 1'b0;
    logic [31:0] t_rd_data, t_wb_adr_o, t_wb_dat_o, t_err_addr;
    logic [3:0]  t_wb_sel_o;
    logic        t_ack, t_wb_we_o, t_wb_cyc_o, t_wb_stb_o, t_bus_err;

    logic [31:0] exp_err_addr = '0;

    kronos_dbus_wb #(.TIMEOUT(255), .ERR_RDATA(ERR1)) u_dut (
        .clk(clk), .rst(rst),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req),
        .data_rd_data(data_rd_data), .data_ack(data_ack),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    kronos_dbus_wb #(.TIMEOUT(4), .ERR_RDATA(ERR2)) u_dut_to (
        .clk(clk), .rst(rst),
        .data_addr(t_addr), .data_wr_data(t_wdata), .data_mask(t_mask),
        .data_wr_en(t_we), .data_req(t_req),
        .data_rd_data(t_rd_data), .data_ack(t_ack),
        .wb_adr_o(t_wb_adr_o), .wb_dat_o(t_wb_dat_o), .wb_sel_o(t_wb_sel_o), .wb_we_o(t_wb_we_o),
        .wb_cyc_o(t_wb_cyc_o), .wb_stb_o(t_wb_stb_o),
        .wb_dat_i(t_wb_dat_i), .wb_ack_i(t_wb_ack_i), .wb_err_i(t_wb_err_i),
        .bus_err(t_bus_err), .err_addr(t_err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the main instance. waits = silent strobe cycles before
    // the slave responds; the core must see data_ack waits+2 edges after req.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                       input logic we, input int waits, input logic rsp_ack,
                       input logic rsp_err, input logic [31:0] rdat);
        int c0;
        @(negedge clk);
        data_addr = a; data_wr_data = wd; data_mask = m; data_wr_en = we; data_req = 1'b1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        @(negedge clk);
        c0 = cyc_cnt;
        for (int k = 0; k <= waits; k++) begin
            chk("stb", {31'b0, wb_stb_o}, 1);
            chk("cyc", {31'b0, wb_cyc_o}, 1);
            chk("adr", wb_adr_o, a);
            chk("dat", wb_dat_o, wd);
            chk("sel", {28'b0, wb_sel_o}, {28'b0, m});
            chk("we", {31'b0, wb_we_o}, {31'b0, we});
            chk("ack_early", {31'b0, data_ack}, 0);
            // data-side fields wander while busy; the bus must not follow them
            data_addr = $urandom; data_wr_data = $urandom; data_mask = 4'($urandom);
            data_wr_en = 1'($urandom);
            if (k == waits) begin
                wb_ack_i = rsp_ack; wb_err_i = rsp_err; wb_dat_i = rdat;
            end
            @(negedge clk);
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        if (rsp_err) exp_err_addr = a;
        chk("data_ack", {31'b0, data_ack}, 1);
        chk("latency", cyc_cnt - c0, waits + 1);
        chk("stb_drop", {31'b0, wb_stb_o}, 0);
        chk("cyc_drop", {31'b0, wb_cyc_o}, 0);
        chk("bus_err", {31'b0, bus_err}, {31'b0, rsp_err});
        if (rsp_err) chk("rd_err", data_rd_data, ERR1);
        else if (!we) chk("rd", data_rd_data, rdat);
        chk("err_addr", err_addr, exp_err_addr);
        data_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", {31'b0, data_ack}, 0);
        chk("berr_pulse", {31'b0, bus_err}, 0);
        chk("stb_idle", {31'b0, wb_stb_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int s1, s2, n, stb_cnt, kind;
        logic [31:0] ra;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
        chk("rst_stb", {31'b0, wb_stb_o}, 0);
        chk("rst_we", {31'b0, wb_we_o}, 0);
        chk("rst_ack", {31'b0, data_ack}, 0);
        chk("rst_berr", {31'b0, bus_err}, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", {28'b0, wb_sel_o}, 0);
        chk("rst_eaddr", err_addr, 0);
        chk("rst_rd", data_rd_data, 0);
        chk("rst_t_cyc", {31'b0, t_wb_cyc_o}, 0);
        rst = 1'b0;

        // Load, store with 5 waits, error together with ack
        txn(32'h100, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b0, 32'hDEADBEEF);
        txn(32'h204, 32'h1234, 4'b0011, 1'b1, 5, 1'b1, 1'b0, 32'h0);
        txn(32'h300, 32'h0, 4'hF, 1'b0, 2, 1'b1, 1'b1, 32'h11111111);

        // Async reset in the second wait cycle of a transaction
        @(negedge clk);
        data_addr = 32'h400; data_mask = 4'hF; data_wr_en = 1'b0; data_req = 1'b1;
        @(negedge clk);
        chk("rst_mid_stb_pre", {31'b0, wb_stb_o}, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_cyc", {31'b0, wb_cyc_o}, 0);
        chk("rst_mid_stb", {31'b0, wb_stb_o}, 0);
        chk("rst_mid_ack", {31'b0, data_ack}, 0);
        data_req = 1'b0;
        exp_err_addr = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ack", {31'b0, data_ack}, 0);
            chk("post_rst_stb", {31'b0, wb_stb_o}, 0);
        end
        txn(32'h440, 32'h0, 4'hF, 1'b0, 1, 1'b1, 1'b0, 32'hCAFEF00D);

        // Back-to-back: request stays high through the response cycle
        @(negedge clk);
        data_addr = 32'h600; data_mask = 4'hF; data_wr_en = 1'b0; data_req = 1'b1;
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5A5A5;
        @(negedge clk);
        s1 = cyc_cnt;
        chk("b2b_stb1", {31'b0, wb_stb_o}, 1);
        chk("b2b_adr1", wb_adr_o, 32'h600);
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("b2b_ack1", {31'b0, data_ack}, 1);
        chk("b2b_rd1", data_rd_data, 32'hA5A5A5A5);
        data_addr = 32'h604;
        @(negedge clk);
        chk("b2b_resp_no_stb", {31'b0, wb_stb_o}, 0);
        chk("b2b_ack_low", {31'b0, data_ack}, 0);
        n = 0;
        while (!wb_stb_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        s2 = cyc_cnt;
        chk("b2b_spacing", s2 - s1, 3);
        chk("b2b_adr2", wb_adr_o, 32'h604);
        wb_ack_i = 1'b1; wb_dat_i = 32'h5A5A5A5A;
        @(negedge clk);
        wb_ack_i = 1'b0; data_req = 1'b0;
        chk("b2b_ack2", {31'b0, data_ack}, 1);
        chk("b2b_rd2", data_rd_data, 32'h5A5A5A5A);
        repeat (3) begin
            @(negedge clk);
            chk("b2b_no_reissue", {31'b0, wb_stb_o}, 0);
        end

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 2));
            txn($urandom, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(0, 6)),
                (kind != 1), (kind != 0), $urandom);
        end

        // Watchdog expiry on the TIMEOUT=4 instance, then a normal load
        @(negedge clk);
        t_addr = 32'h500; t_mask = 4'hF; t_we = 1'b0; t_req = 1'b1;
        @(negedge clk);
        s1 = cyc_cnt;
        n = 0; stb_cnt = 0;
        while (!t_ack && n < 20) begin
            if (t_wb_stb_o) stb_cnt++;
            @(negedge clk);
            n++;
        end
        chk("to_latency", cyc_cnt - s1, 5);
        chk("to_stb_cycles", stb_cnt, 5);
        chk("to_ack", {31'b0, t_ack}, 1);
        chk("to_berr", {31'b0, t_bus_err}, 1);
        chk("to_cyc", {31'b0, t_wb_cyc_o}, 0);
        chk("to_rd", t_rd_data, ERR2);
        chk("to_eaddr", t_err_addr, 32'h500);
        t_req = 1'b0;
        @(negedge clk);
        chk("to_ack_pulse", {31'b0, t_ack}, 0);
        ra = 32'h5555AAAA;
        t_addr = 32'h504; t_req = 1'b1;
        @(negedge clk);
        s1 = cyc_cnt;
        chk("to2_adr", t_wb_adr_o, 32'h504);
        @(negedge clk);
        t_wb_ack_i = 1'b1; t_wb_dat_i = ra;
        @(negedge clk);
        t_wb_ack_i = 1'b0; t_req = 1'b0;
        chk("to2_latency", cyc_cnt - s1, 2);
        chk("to2_ack", {31'b0, t_ack}, 1);
        chk("to2_berr", {31'b0, t_bus_err}, 0);
        chk("to2_rd", t_rd_data, ra);
        chk("to2_eaddr", t_err_addr, 32'h500);
        chk("to2_sel", {28'b0, t_wb_sel_o}, 32'hF);
        chk("to2_we", {31'b0, t_wb_we_o}, 0);
        chk("to2_dat", t_wb_dat_o, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
